// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - 256-bit line port to 4 x 64-bit burst memory adaptor
// Latches one line request in IDLE, runs a 4-beat burst, then pulses pmem_resp in DONE.

module cacheline_adaptor (
   input  logic         clk,
   input  logic         rst,

   input  logic         pmem_read,
   input  logic         pmem_write,
   input  logic [31:0]  pmem_address,
   input  logic [255:0] pmem_wdata,
   output logic [255:0] pmem_rdata,
   output logic         pmem_resp,

   output logic [31:0]  bmem_address,
   output logic         bmem_read,
   output logic         bmem_write,
   output logic [63:0]  bmem_wdata,
   input  logic [63:0]  bmem_rdata,
   input  logic         bmem_resp
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [1:0]    r_cnt;
   logic [26:0]   r_addr;
   logic [255:0]  r_wline;
   logic [255:0]  r_rline;

   logic          w_start_wr;
   logic          w_start_rd;
   logic          w_beat;
   logic [7:0]    w_beat_lsb;
   logic          w_unused_addr_lsbs;

   // Line offset bits never reach the burst side; the burst always starts at beat 0.
   assign w_unused_addr_lsbs = ^pmem_address[4:0];
   assign w_beat_lsb         = {r_cnt, 6'b0};
   assign pmem_rdata         = r_rline;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next       = r_state;
      w_start_wr   = 1'b0;
      w_start_rd   = 1'b0;
      w_beat       = 1'b0;
      pmem_resp    = 1'b0;
      bmem_read    = 1'b0;
      bmem_write   = 1'b0;
      bmem_address = 32'h0;
      bmem_wdata   = 64'h0;
      case (r_state)
         ST_IDLE: begin
            if (pmem_write) begin
               w_start_wr = 1'b1;
               w_next     = ST_WRITE;
            end else if (pmem_read) begin
               w_start_rd = 1'b1;
               w_next     = ST_READ;
            end
         end
         ST_READ: begin
            bmem_read    = 1'b1;
            bmem_address = {r_addr, 5'b0};
            if (bmem_resp) begin
               w_beat = 1'b1;
               if (r_cnt == 2'd3) begin
                  w_next = ST_DONE;
               end
            end
         end
         ST_WRITE: begin
            bmem_write   = 1'b1;
            bmem_address = {r_addr, 5'b0};
            bmem_wdata   = r_wline[w_beat_lsb +: 64];
            if (bmem_resp) begin
               w_beat = 1'b1;
               if (r_cnt == 2'd3) begin
                  w_next = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            pmem_resp = 1'b1;
            w_next    = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // The counter wraps 3->0 on the final beat, which is also the DONE transition.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= 2'd0;
         r_addr  <= 27'h0;
         r_wline <= 256'h0;
         r_rline <= 256'h0;
      end else begin
         if (w_start_wr || w_start_rd) begin
            r_addr <= pmem_address[31:5];
            r_cnt  <= 2'd0;
         end
         if (w_start_wr) begin
            r_wline <= pmem_wdata;
         end
         if (w_beat) begin
            r_cnt <= r_cnt + 2'd1;
            if (r_state == ST_READ) begin
               r_rline[w_beat_lsb +: 64] <= bmem_rdata;
            end
         end
      end
   end

   a_no_dual_req: assert property (@(posedge clk) !(bmem_read && bmem_write));
   a_resp_single: assert property (@(posedge clk) disable iff (rst) pmem_resp |=> !pmem_resp);
   a_done_cnt:    assert property (@(posedge clk) disable iff (rst) (r_state == ST_DONE) |-> (r_cnt == 2'd0));

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb/tb_cacheline_adaptor.sv - directed self-checking bench for cacheline_adaptor
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.

module tb_cacheline_adaptor;

   logic         clk;
   logic         rst;
   logic         pmem_read;
   logic         pmem_write;
   logic [31:0]  pmem_address;
   logic [255:0] pmem_wdata;
   logic [255:0] pmem_rdata;
   logic         pmem_resp;
   logic [31:0]  bmem_address;
   logic         bmem_read;
   logic         bmem_write;
   logic [63:0]  bmem_wdata;
   logic [63:0]  bmem_rdata;
   logic         bmem_resp;

   int           checks;
   int           errors;
   logic [255:0] last_line;

   cacheline_adaptor dut (
      .clk          (clk),
      .rst          (rst),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp),
      .bmem_address (bmem_address),
      .bmem_read    (bmem_read),
      .bmem_write   (bmem_write),
      .bmem_wdata   (bmem_wdata),
      .bmem_rdata   (bmem_rdata),
      .bmem_resp    (bmem_resp)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic test_reset();
      rst = 1'b1; pmem_read = 1'b0; pmem_write = 1'b0; pmem_address = 32'h0;
      pmem_wdata = 256'h0; bmem_rdata = 64'h0; bmem_resp = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (pmem_resp !== 1'b0) begin errors++; $display("FAIL rst_pmem_resp: got %b expected 0", pmem_resp); end
      checks++; if (pmem_rdata !== 256'h0) begin errors++; $display("FAIL rst_pmem_rdata: got %h expected 0", pmem_rdata); end
      checks++; if (bmem_read !== 1'b0) begin errors++; $display("FAIL rst_bmem_read: got %b expected 0", bmem_read); end
      checks++; if (bmem_write !== 1'b0) begin errors++; $display("FAIL rst_bmem_write: got %b expected 0", bmem_write); end
      checks++; if (bmem_address !== 32'h0) begin errors++; $display("FAIL rst_bmem_address: got %h expected 0", bmem_address); end
      checks++; if (bmem_wdata !== 64'h0) begin errors++; $display("FAIL rst_bmem_wdata: got %h expected 0", bmem_wdata); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_read_zero_wait();
      logic [63:0] b [4];
      b[0] = 64'h1111_1111_1111_1111; b[1] = 64'h2222_2222_2222_2222;
      b[2] = 64'h3333_3333_3333_3333; b[3] = 64'h4444_4444_4444_4444;
      pmem_read = 1'b1; pmem_address = 32'h0000_1234;
      checks++; if (bmem_read !== 1'b0) begin errors++; $display("FAIL rd_idle_bmem_read: got %b expected 0", bmem_read); end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k == 0) pmem_address = 32'hFFFF_FFFF;
         checks++; if (bmem_read !== 1'b1) begin errors++; $display("FAIL rd_bmem_read beat %0d: got %b expected 1", k, bmem_read); end
         checks++; if (bmem_address !== 32'h0000_1220) begin errors++; $display("FAIL rd_bmem_address beat %0d: got %h expected 00001220", k, bmem_address); end
         checks++; if (pmem_resp !== 1'b0) begin errors++; $display("FAIL rd_early_resp beat %0d: got %b expected 0", k, pmem_resp); end
         bmem_resp = 1'b1; bmem_rdata = b[k];
      end
      @(negedge clk);
      bmem_resp = 1'b0;
      checks++; if (pmem_resp !== 1'b1) begin errors++; $display("FAIL rd_pmem_resp: got %b expected 1", pmem_resp); end
      checks++; if (bmem_read !== 1'b0) begin errors++; $display("FAIL rd_done_bmem_read: got %b expected 0", bmem_read); end
      checks++; if (pmem_rdata !== {b[3], b[2], b[1], b[0]}) begin errors++; $display("FAIL rd_line: got %h expected %h", pmem_rdata, {b[3], b[2], b[1], b[0]}); end
      pmem_read = 1'b0; pmem_address = 32'h0;
      @(negedge clk);
      checks++; if (pmem_resp !== 1'b0) begin errors++; $display("FAIL rd_resp_width: got %b expected 0", pmem_resp); end
      checks++; if (pmem_rdata !== {b[3], b[2], b[1], b[0]}) begin errors++; $display("FAIL rd_line_hold: got %h expected %h", pmem_rdata, {b[3], b[2], b[1], b[0]}); end
      last_line = {b[3], b[2], b[1], b[0]};
   endtask

   task automatic test_write_waits();
      logic [63:0] d [4];
      d[0] = 64'hD0D0_0000_0000_00D0; d[1] = 64'hD1D1_0000_0000_00D1;
      d[2] = 64'hD2D2_0000_0000_00D2; d[3] = 64'hD3D3_0000_0000_00D3;
      pmem_write = 1'b1; pmem_address = 32'h8000_00FF; pmem_wdata = {d[3], d[2], d[1], d[0]};
      for (int k = 0; k < 4; k++) begin
         for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            if (k == 0 && g == 0) begin pmem_wdata = '1; pmem_address = 32'h0; end
            checks++; if (bmem_write !== 1'b1 || bmem_read !== 1'b0) begin errors++; $display("FAIL wr_req beat %0d gap %0d: got w=%b r=%b expected w=1 r=0", k, g, bmem_write, bmem_read); end
            checks++; if (bmem_wdata !== d[k]) begin errors++; $display("FAIL wr_wdata beat %0d gap %0d: got %h expected %h", k, g, bmem_wdata, d[k]); end
            checks++; if (bmem_address !== 32'h8000_00E0) begin errors++; $display("FAIL wr_bmem_address: got %h expected 800000e0", bmem_address); end
            bmem_resp = (g == 2);
         end
      end
      @(negedge clk);
      bmem_resp = 1'b0;
      checks++; if (pmem_resp !== 1'b1) begin errors++; $display("FAIL wr_pmem_resp: got %b expected 1", pmem_resp); end
      checks++; if (bmem_write !== 1'b0) begin errors++; $display("FAIL wr_done_bmem_write: got %b expected 0", bmem_write); end
      checks++; if (pmem_rdata !== last_line) begin errors++; $display("FAIL wr_rdata_kept: got %h expected %h", pmem_rdata, last_line); end
      pmem_write = 1'b0;
      @(negedge clk);
      checks++; if (pmem_resp !== 1'b0) begin errors++; $display("FAIL wr_resp_width: got %b expected 0", pmem_resp); end
   endtask

   task automatic test_simultaneous();
      pmem_read = 1'b1; pmem_write = 1'b1; pmem_address = 32'h0000_0040;
      pmem_wdata = {4{64'h5A5A_5A5A_5A5A_5A5A}};
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++; if (bmem_write !== 1'b1 || bmem_read !== 1'b0) begin errors++; $display("FAIL sim_req beat %0d: got w=%b r=%b expected w=1 r=0", k, bmem_write, bmem_read); end
         bmem_resp = 1'b1; bmem_rdata = 64'hBAD0_0000_0000_0000 | 64'(k);
      end
      @(negedge clk);
      bmem_resp = 1'b0;
      checks++; if (pmem_resp !== 1'b1) begin errors++; $display("FAIL sim_pmem_resp: got %b expected 1", pmem_resp); end
      checks++; if (pmem_rdata !== last_line) begin errors++; $display("FAIL sim_no_capture: got %h expected %h", pmem_rdata, last_line); end
      pmem_read = 1'b0; pmem_write = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [63:0] r [4];
      int          resp_cnt;
      r[0] = 64'hC0C0_C0C0_0000_0001; r[1] = 64'hC1C1_C1C1_0000_0002;
      r[2] = 64'hC2C2_C2C2_0000_0003; r[3] = 64'hC3C3_C3C3_0000_0004;
      resp_cnt = 0;
      pmem_write = 1'b1; pmem_address = 32'h0000_1000; pmem_wdata = {4{64'h7777_0000_7777_0000}};
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (pmem_resp === 1'b1) resp_cnt++;
         bmem_resp = 1'b1;
      end
      @(negedge clk);
      if (pmem_resp === 1'b1) resp_cnt++;
      bmem_resp = 1'b0; pmem_write = 1'b0;
      @(negedge clk);
      if (pmem_resp === 1'b1) resp_cnt++;
      checks++; if (bmem_read !== 1'b0 || bmem_write !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got r=%b w=%b expected 0 0", bmem_read, bmem_write); end
      pmem_read = 1'b1; pmem_address = 32'h0000_2047;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (pmem_resp === 1'b1) resp_cnt++;
         checks++; if (bmem_read !== 1'b1 || bmem_address !== 32'h0000_2040) begin errors++; $display("FAIL b2b_read beat %0d: got r=%b addr=%h expected r=1 addr=00002040", k, bmem_read, bmem_address); end
         bmem_resp = 1'b1; bmem_rdata = r[k];
      end
      @(negedge clk);
      if (pmem_resp === 1'b1) resp_cnt++;
      bmem_resp = 1'b0; pmem_read = 1'b0;
      checks++; if (pmem_rdata !== {r[3], r[2], r[1], r[0]}) begin errors++; $display("FAIL b2b_line: got %h expected %h", pmem_rdata, {r[3], r[2], r[1], r[0]}); end
      @(negedge clk);
      if (pmem_resp === 1'b1) resp_cnt++;
      checks++; if (resp_cnt !== 2) begin errors++; $display("FAIL b2b_resp_count: got %0d expected 2", resp_cnt); end
      last_line = {r[3], r[2], r[1], r[0]};
   endtask

   task automatic test_reset_mid_read();
      logic [63:0] f [4];
      f[0] = 64'hF000_0000_0000_000F; f[1] = 64'hF111_0000_0000_001F;
      f[2] = 64'hF222_0000_0000_002F; f[3] = 64'hF333_0000_0000_003F;
      pmem_read = 1'b1; pmem_address = 32'h0000_3000;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         bmem_resp = 1'b1; bmem_rdata = 64'hEEEE_0000_0000_0000 | 64'(k);
      end
      @(negedge clk);
      rst = 1'b1; bmem_resp = 1'b1; bmem_rdata = 64'hEEEE_EEEE_EEEE_EEEE;
      @(negedge clk);
      checks++; if (bmem_read !== 1'b0 || pmem_resp !== 1'b0) begin errors++; $display("FAIL rstrd_abort: got r=%b resp=%b expected 0 0", bmem_read, pmem_resp); end
      checks++; if (bmem_address !== 32'h0 || pmem_rdata !== 256'h0) begin errors++; $display("FAIL rstrd_cleared: got addr=%h rdata=%h expected 0", bmem_address, pmem_rdata); end
      rst = 1'b0; bmem_resp = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++; if (bmem_read !== 1'b1 || bmem_address !== 32'h0000_3000) begin errors++; $display("FAIL rstrd_reissue beat %0d: got r=%b addr=%h expected r=1 addr=00003000", k, bmem_read, bmem_address); end
         bmem_resp = 1'b1; bmem_rdata = f[k];
      end
      @(negedge clk);
      bmem_resp = 1'b0; pmem_read = 1'b0;
      checks++; if (pmem_resp !== 1'b1) begin errors++; $display("FAIL rstrd_resp: got %b expected 1", pmem_resp); end
      checks++; if (pmem_rdata !== {f[3], f[2], f[1], f[0]}) begin errors++; $display("FAIL rstrd_line: got %h expected %h", pmem_rdata, {f[3], f[2], f[1], f[0]}); end
      @(negedge clk);
      last_line = {f[3], f[2], f[1], f[0]};
   endtask

   task automatic test_spurious();
      logic [63:0] h [4];
      h[0] = 64'h0101_0101_0101_0101; h[1] = 64'h0202_0202_0202_0202;
      h[2] = 64'h0303_0303_0303_0303; h[3] = 64'h0404_0404_0404_0404;
      bmem_resp = 1'b1; bmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      repeat (2) begin
         @(negedge clk);
         checks++; if (bmem_read !== 1'b0 || bmem_write !== 1'b0 || pmem_resp !== 1'b0) begin errors++; $display("FAIL spur_idle_outputs: got r=%b w=%b resp=%b expected 0 0 0", bmem_read, bmem_write, pmem_resp); end
         checks++; if (pmem_rdata !== last_line) begin errors++; $display("FAIL spur_idle_rdata: got %h expected %h", pmem_rdata, last_line); end
      end
      bmem_resp = 1'b0;
      pmem_read = 1'b1; pmem_address = 32'h0000_4000;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         bmem_resp = 1'b1; bmem_rdata = h[k];
      end
      @(negedge clk);
      pmem_read = 1'b0; bmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      checks++; if (pmem_resp !== 1'b1) begin errors++; $display("FAIL spur_read_resp: got %b expected 1", pmem_resp); end
      @(negedge clk);
      checks++; if (pmem_rdata !== {h[3], h[2], h[1], h[0]} || pmem_resp !== 1'b0) begin errors++; $display("FAIL spur_done_rdata: got %h resp=%b expected %h resp=0", pmem_rdata, pmem_resp, {h[3], h[2], h[1], h[0]}); end
      bmem_resp = 1'b0;
      pmem_read = 1'b1; pmem_address = 32'h0000_5000;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         bmem_resp = 1'b1; bmem_rdata = h[3 - k];
      end
      @(negedge clk);
      bmem_resp = 1'b0; pmem_read = 1'b0;
      checks++; if (pmem_rdata !== {h[0], h[1], h[2], h[3]}) begin errors++; $display("FAIL spur_cnt_intact: got %h expected %h", pmem_rdata, {h[0], h[1], h[2], h[3]}); end
      @(negedge clk);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      last_line = 256'h0;
      test_reset();
      test_read_zero_wait();
      test_write_waits();
      test_simultaneous();
      test_back_to_back();
      test_reset_mid_read();
      test_spurious();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
